// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle sequencer for a shared-memory, shared-ALU datapath. Each
//   instruction goes through fetch, decode, execute, memory and writeback
//   states. The block drives the memory handshake, the PC/IR write enables,
//   the operand muxes and the ALU op class, and it counts retired instructions.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode, funct     IR[31:26] and IR[5:0], stable from DECODE to next FETCH
//   mem_ready         memory finishes the current read/write this cycle
//   mem_read/write    memory request strobes
//   iord              address mux select (0=PC, 1=ALUOut)
//   ir_write          IR load enable
//   pc_write          unconditional PC write
//   pc_write_cond     PC write qualified by the branch condition
//   pc_src            00=ALU result, 01=ALUOut, 10=jump target
//   branch_src        0=equal, 1=greater-than
//   alu_src_a/b       ALU operand mux selects
//   alu_op            00=add, 01=sub/compare, 10=funct-decoded, 11=xor
//   sign_zero         0=sign-extend, 1=zero-extend immediate
//   reg_dst           1=rd, 0=rt
//   mem_to_reg        1=memory data, 0=ALUOut
//   reg_write         register file write enable
//   state             current state (debug)
//   illegal           one-cycle pulse in DECODE on an unsupported opcode
//   retired           retired instruction count, wraps modulo 2^CNT_W
//
// state  | meaning
// -------+-------------------------------------------------
// FETCH  | read instruction at PC, PC+4 into PC on mem_ready
// DECODE | decode opcode, branch target into ALUOut
// MEMADR | compute load/store address
// MEMRD  | load data read, wait for mem_ready
// MEMWB  | write load data into rt
// MEMWR  | store data write, wait for mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result into rd
// BRANCH | compare and conditionally update PC
// JUMP   | load jump target into PC
// XEXEC  | xori ALU operation (zero-extended immediate)
// XWB    | write xori result into rt

module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             branch_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             sign_zero,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_XEXEC  = 4'd10,
        S_XWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BGT   = 6'h05;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t           state_q;
    state_t           state_d;
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        retire        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        branch_src    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        sign_zero     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                branch_src = (opcode == OP_BGT);
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_BEQ, OP_BGT: state_d = S_BRANCH;
                    OP_XORI:        state_d = S_XEXEC;
                    OP_J:           state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                // shifts take the shift amount from the immediate field
                alu_src_b = (funct == 6'h00 || funct == 6'h02) ? 2'b10 : 2'b00;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_XEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                sign_zero = 1'b1;
                state_d   = S_XWB;
            end
            S_XWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                branch_src    = (opcode == OP_BGT);
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            // encodings 12-15: all outputs stay 0, recover to FETCH
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the processor datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the shared-memory handshake, the PC/IR write enables, the operand muxes and the ALU op class. It also counts retired instructions. It replaces single-cycle decode when the datapath shares one memory port and one ALU across cycles.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- opcode  in  6  IR[31:26], stable from DECODE until next FETCH
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes current read/write this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  address mux: 0=PC, 1=ALUOut
- ir_write  out  1  load IR from memory data
- pc_write  out  1  unconditional PC write
- pc_write_cond  out  1  PC write qualified by branch condition
- pc_src  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
- branch_src  out  1  0=equal, 1=greater-than condition
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  00=register B, 01=constant 4, 10=extended immediate, 11=extended immediate<<2
- alu_op  out  2  00=add, 01=compare/subtract, 10=funct-decoded, 11=xor
- sign_zero  out  1  0=sign-extend, 1=zero-extend immediate
- reg_dst  out  1  1=rd, 0=rt
- mem_to_reg  out  1  1=memory data, 0=ALUOut
- reg_write  out  1  register file write
- state  out  4  current state, for debug
- illegal  out  1  one-cycle pulse on unsupported opcode
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, XEXEC=10, XWB=11.
- Unlisted outputs are 0 in each state. Outputs are decoded from state, except where "on mem_ready" is stated.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=1 and pc_write=1 only when mem_ready=1.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, sign_zero=0 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) → MEMADR
  - 101011 (sw) → MEMADR
  - 000000 → EXEC
  - 000100 (beq) → BRANCH, with branch_src=0
  - 000101 (bgt) → BRANCH, with branch_src=1
  - 001110 (xori) → XEXEC
  - 000010 (j) → JUMP
  - any other opcode: illegal=1 for this cycle, → FETCH
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00, sign_zero=0. Go to MEMRD if opcode=lw, else MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then → MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready, then → FETCH.
- EXEC: alu_src_a=1, alu_op=10. alu_src_b=10 when funct is 00h or 02h (shift), else 00 → ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- XEXEC: alu_src_a=1, alu_src_b=10, alu_op=11, sign_zero=1 → XWB.
- XWB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. branch_src is 0 for beq, 1 for bgt → FETCH.
- JUMP: pc_write=1, pc_src=10 → FETCH.
- retired increments by 1 on the clock edge that leaves any of these states: MEMWB, MEMWR (on mem_ready), ALUWB, XWB, BRANCH, JUMP. An illegal opcode does not increment it.
- State register encodings 12–15 are unreachable. If entered anyway, the block returns to FETCH next cycle with all outputs 0.

## Timing
- While rst_n=0:
  - state=FETCH, retired=0, illegal=0.
  - Outputs take their FETCH values: mem_read=1, alu_src_b=01, all others 0.
  - ir_write and pc_write also require mem_ready.
- Reset asserted mid-instruction takes effect immediately, asynchronously. Any pending memory access is abandoned: mem_write drops the same instant. No register write occurs.
- Minimum latency with zero wait states, FETCH to next FETCH:
  - lw: 5 cycles
  - sw, R-type, xori: 4 cycles
  - beq, bgt, j: 3 cycles
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Memory request signals stay asserted and constant until the cycle mem_ready=1 is sampled. mem_ready outside these states is ignored.
- At retired=2^CNT_W-1, the next retirement wraps it to 0.

## Test plan
- Reset: rst_n low for 3 cycles, mem_ready=0 → state=0, mem_read=1, alu_src_b=01, ir_write=0, retired=0. After release, state holds 0 while mem_ready=0.
- lw (opcode 23h), mem_ready always 1 → states 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1 only in state 4. retired=1 after 5 cycles.
- sw (opcode 2Bh), mem_ready low for 2 cycles in MEMWR → mem_write=1 for 3 cycles, iord=1, reg_write never 1. retired increments once.
- R-type: funct=20h → EXEC with alu_src_b=00, alu_op=10. funct=00h → EXEC with alu_src_b=10. Both: ALUWB with reg_dst=1.
- Branches: bgt (05h) → BRANCH with pc_write_cond=1, pc_src=01, branch_src=1, 3-cycle total. j (02h) → JUMP with pc_write=1, pc_src=10.
- Illegal opcode 3Fh → illegal pulses for 1 cycle in DECODE, next state 0, retired unchanged. Separately: assert rst_n=0 in MEMWR with mem_ready=0 → mem_write=0 immediately, state=0.
